// File: rtl/conv_encoder.sv
// K=7 rate-1/2 convolutional encoder with a bit-wide input FIFO and a serial
// A/B output stream; encoder state runs continuously across frames.
module conv_encoder #(
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [6:0]  G_A        = 7'o133,
  parameter logic [6:0]  G_B        = 7'o171
) (
  input  logic Clk,
  input  logic reset,
  input  logic in,
  input  logic valid_in,
  output logic in_ready,
  output logic out,
  output logic valid_out,
  input  logic out_ready,
  output logic frame_start
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;

  state_t              state, state_n;
  logic [FIFO_DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic [5:0]          sr;
  logic [FCNT_W-1:0]   fcnt;
  logic                b_hold;
  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic                head, code_a, code_b;

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // Forced high while reset is asserted so upstream never sees backpressure then.
  assign in_ready   = !fifo_full || !reset;
  assign push       = valid_in && !fifo_full;

  assign head   = fifo_mem[rd_ptr];
  assign code_a = ^(G_A & {head, sr});
  assign code_b = ^(G_B & {head, sr});

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = EMIT_A;
        end
      end
      EMIT_A: begin
        if (out_ready) state_n = EMIT_B;
      end
      EMIT_B: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = EMIT_A;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state       <= IDLE;
      fifo_mem    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sr          <= '0;
      fcnt        <= '0;
      b_hold      <= 1'b0;
      out         <= 1'b0;
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      if (push) begin
        fifo_mem[wr_ptr] <= in;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A pop loads both coded bits at once; B waits in b_hold until A is taken.
      if (pop) begin
        out         <= code_a;
        b_hold      <= code_b;
        sr          <= {head, sr[5:1]};
        valid_out   <= 1'b1;
        frame_start <= (fcnt == '0);
        fcnt        <= (fcnt == FCNT_W'(FRAME_BITS - 1)) ? '0 : fcnt + 1'b1;
      end else if (state == EMIT_A && out_ready) begin
        out         <= b_hold;
        frame_start <= 1'b0;
      end else if (state == EMIT_B && out_ready) begin
        valid_out   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 24, giving the number of information bits per frame.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the input FIFO depth in bits (power of two, at least 2).
REQ-003 The block SHALL have parameter G_A, default 7'o133, giving the generator taps for coded bit A; bit 6 taps the current input bit.
REQ-004 The block SHALL have parameter G_B, default 7'o171, giving the generator taps for coded bit B, with the same bit mapping as G_A.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port in, input, 1 bit: the information bit.
REQ-008 The block SHALL have port valid_in, input, 1 bit: `in` is valid this cycle.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts `in` this cycle.
REQ-010 The block SHALL have port out, output, 1 bit: the serial coded bit, A then B for each information bit.
REQ-011 The block SHALL have port valid_out, output, 1 bit: `out` is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumes `out` this cycle.
REQ-013 The block SHALL have port frame_start, output, 1 bit: high with valid_out while `out` is the A bit of frame bit index 0.

Function
REQ-014 The block SHALL accept a bit on any edge where valid_in=1 and in_ready=1, and write it to the FIFO tail.
REQ-015 The block SHALL drive in_ready = !fifo_full combinationally, so that in_ready does not depend on valid_in.
REQ-016 The block SHALL hold a 6-bit shift register sr, where sr[5] is the newest past bit; for each information bit d, sr SHALL update to {d, sr[5:1]}.
REQ-017 The block SHALL compute the coded bits as A = XOR-reduce(G_A & {d, sr}) and B = XOR-reduce(G_B & {d, sr}), using sr before its update.
REQ-018 The block SHALL never re-zero sr between frames; sr is continuous across frames and cleared only by reset.
REQ-019 The block SHALL implement an FSM with states IDLE, EMIT_A and EMIT_B.
REQ-020 In IDLE with the FIFO non-empty, the block SHALL, on the edge: pop the FIFO, register out=A, hold B, update sr, set valid_out=1, and go to EMIT_A.
REQ-021 In EMIT_A with out_ready=1, the block SHALL set out=B and go to EMIT_B; with out_ready=0 it SHALL hold out and valid_out.
REQ-022 In EMIT_B with out_ready=1 and the FIFO non-empty, the block SHALL pop and emit the next A with no bubble, and go to EMIT_A.
REQ-023 In EMIT_B with out_ready=1 and the FIFO empty, the block SHALL set valid_out=0 and go to IDLE.
REQ-024 In EMIT_B with out_ready=0, the block SHALL hold out and valid_out.
REQ-025 Latency SHALL be: a bit accepted on edge E with an empty FIFO in IDLE appears as A after edge E+1.
REQ-026 The block SHALL allow a push and a pop on the same edge; the FIFO count is then unchanged.
REQ-027 Write and read pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 The block SHALL keep frame counter fcnt, range 0..FRAME_BITS-1, incremented at each pop, wrapping from FRAME_BITS-1 to 0.
REQ-029 frame_start SHALL be high exactly while in EMIT_A for the bit popped with fcnt=0.
REQ-030 With sustained valid_in and out_ready, the block SHALL produce 2*FRAME_BITS coded bits per frame, with valid_out continuously high and in_ready never low for more than FIFO_DEPTH-1 consecutive cycles after fill.

Reset
REQ-031 When reset=0 on an edge, the block SHALL clear the FIFO, sr, fcnt and the FSM (to IDLE), and set out=0, valid_out=0 and frame_start=0.
REQ-032 In-flight bits SHALL be discarded on reset.
REQ-033 in_ready SHALL be 1 during reset.
REQ-034 A reset asserted mid-frame SHALL restart with the next accepted bit as frame index 0 and sr=0.

Verification
REQ-035 Scenario: after reset, input bits 1,0,0 with out_ready=1 -> out = 1,1, 0,1, 1,1; frame_start high on the first A only.
REQ-036 Scenario: single bit 1 accepted at edge E -> valid_out rises after E+1 with out=1; after E+2 out=1 (B); after E+3 valid_out=0.
REQ-037 Scenario: out_ready=0 with continuous valid_in -> exactly FIFO_DEPTH bits plus 1 (held in the FSM) accepted, then in_ready=0; out is stable; releasing out_ready drains in order with no loss.
REQ-038 Scenario: 48 random bits streamed -> 96 coded bits match a software K=7 133/171 encoder with continuous state; frame_start pulses at coded bit 0 and coded bit 48.
REQ-039 Scenario: reset at frame bit 10 -> outputs clear the next cycle; the next input 1 yields out=1,1 with frame_start=1.
REQ-040 Scenario: push and pop on the same edge with the FIFO at DEPTH-1 -> count unchanged, in_ready stays 1, no duplicated or dropped bit.
